// File: rtl/nexi_uart_tx_arbiter.sv
// Round-robin arbiter sharing one nexi_uart_tx between N_REQ byte producers.
// Supports a per-requester packet lock and flags a transmitter that never acknowledges a send.
module nexi_uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int IDX_W       = 2,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic               clk_1x_bps,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_lock,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_command_send,
  output logic [7:0]         tx_data,
  input  logic               tx_done_ack,
  output logic [IDX_W-1:0]   grant_id,
  output logic               busy,
  output logic               timeout_err
);

  typedef enum logic [1:0] {IDLE, REQ, BUSY, RECOVER} state_t;

  localparam logic [7:0] WAIT_LAST    = 8'(ACK_TIMEOUT - 1);
  localparam logic [7:0] RECOVER_LAST = 8'd2;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0] grant_nxt, winner;
  logic             lock_hold, lock_hold_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic [7:0]       data_nxt;
  logic             send_nxt;
  logic [N_REQ-1:0] ready_nxt;
  logic             terr_nxt;

  // First valid index after ptr in cyclic order; scanned backwards so the nearest wins.
  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] ptr,
                                               input logic [N_REQ-1:0] vld);
    logic [IDX_W-1:0] pick;
    int               idx;
    pick = ptr;
    for (int off = N_REQ; off >= 1; off--) begin
      idx = (int'(ptr) + off) % N_REQ;
      if (vld[IDX_W'(idx)]) pick = IDX_W'(idx);
    end
    return pick;
  endfunction

  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    grant_nxt     = grant_id;
    lock_hold_nxt = lock_hold;
    cnt_nxt       = cnt;
    data_nxt      = tx_data;
    send_nxt      = tx_command_send;
    ready_nxt     = '0;
    terr_nxt      = 1'b0;
    winner        = (lock_hold && req_valid[grant_id]) ? grant_id : rr_next(rr_ptr, req_valid);
    case (state)
      IDLE: begin
        // A lock survives only while its owner keeps requesting.
        if (lock_hold && !req_valid[grant_id]) lock_hold_nxt = 1'b0;
        if (tx_done_ack && |req_valid) begin
          grant_nxt  = winner;
          data_nxt   = req_data[{winner, 3'b000} +: 8];
          send_nxt   = 1'b1;
          rr_ptr_nxt = winner;
          cnt_nxt    = '0;
          state_nxt  = REQ;
        end
      end
      REQ: begin
        cnt_nxt = cnt + 8'd1;
        if (!tx_done_ack) begin
          send_nxt            = 1'b0;
          ready_nxt[grant_id] = 1'b1;
          lock_hold_nxt       = req_lock[grant_id];
          state_nxt           = BUSY;
        end else if (cnt == WAIT_LAST) begin
          send_nxt      = 1'b0;
          terr_nxt      = 1'b1;
          lock_hold_nxt = 1'b0;
          cnt_nxt       = '0;
          state_nxt     = RECOVER;
        end
      end
      BUSY: begin
        if (tx_done_ack) state_nxt = IDLE;
      end
      RECOVER: begin
        // Gives the transmitter's command synchronizer time to drain.
        if (cnt == RECOVER_LAST) state_nxt = IDLE;
        else cnt_nxt = cnt + 8'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_1x_bps) begin
    if (rst) begin
      state           <= IDLE;
      rr_ptr          <= IDX_W'(N_REQ - 1);
      grant_id        <= '0;
      lock_hold       <= 1'b0;
      cnt             <= '0;
      tx_data         <= '0;
      tx_command_send <= 1'b0;
      req_ready       <= '0;
      timeout_err     <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state           <= state_nxt;
      rr_ptr          <= rr_ptr_nxt;
      grant_id        <= grant_nxt;
      lock_hold       <= lock_hold_nxt;
      cnt             <= cnt_nxt;
      tx_data         <= data_nxt;
      tx_command_send <= send_nxt;
      req_ready       <= ready_nxt;
      timeout_err     <= terr_nxt;
      busy            <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_nexi_uart_tx_arbiter.sv
// Testbench for nexi_uart_tx_arbiter: cycle table, directed corner sequences and
// randomized multi-requester traffic against a transaction-level model.
module tb_nexi_uart_tx_arbiter;
  localparam int N_REQ = 4, IDX_W = 2, ACK_TIMEOUT = 8;

  logic               clk_1x_bps = 1'b0;
  logic               rst = 1'b1;
  logic [N_REQ-1:0]   req_valid = '0, req_lock = '0;
  logic [8*N_REQ-1:0] req_data = '0;
  logic [N_REQ-1:0]   req_ready;
  logic               tx_command_send;
  logic [7:0]         tx_data;
  logic               tx_done_ack;
  logic [IDX_W-1:0]   grant_id;
  logic               busy, timeout_err;

  int n_vec = 0, n_err = 0;
  logic tx_mode = 1'b1;   // 1: done_ack driven by force_ack, 0: by the transmitter model
  logic force_ack = 1'b1;

  nexi_uart_tx_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk_1x_bps(clk_1x_bps), .rst(rst), .req_valid(req_valid), .req_lock(req_lock),
    .req_data(req_data), .req_ready(req_ready), .tx_command_send(tx_command_send),
    .tx_data(tx_data), .tx_done_ack(tx_done_ack), .grant_id(grant_id), .busy(busy),
    .timeout_err(timeout_err));

  always #5 clk_1x_bps = ~clk_1x_bps;

  // Transmitter model: 2-flop command synchronizer, then start, 8 data bits LSB first, stop.
  logic       s1 = 1'b0, s2 = 1'b0, m_ack = 1'b1, line = 1'b1;
  logic [8:0] sh = '1;
  int         nbits = 0;
  logic [7:0] sent_q[$];
  always @(posedge clk_1x_bps) begin
    s1 <= tx_command_send;
    s2 <= s1;
    if (m_ack) begin
      if (s2) begin
        m_ack <= 1'b0; line <= 1'b0; sh <= {1'b1, tx_data}; nbits <= 9;
        sent_q.push_back(tx_data);
      end
    end else if (nbits != 0) begin
      line <= sh[0]; sh <= {1'b0, sh[8:1]}; nbits <= nbits - 1;
    end else begin
      m_ack <= 1'b1; line <= 1'b1;
    end
  end
  assign tx_done_ack = tx_mode ? force_ack : m_ack;

  // Event monitor on the inactive edge.
  int               cyc = 0;
  logic             cmd_d = 1'b0;
  int               rise_q[$], terr_q[$], rdy_cyc_q[$];
  logic [N_REQ-1:0] rdy_q[$];
  logic             line_q[$];
  always @(negedge clk_1x_bps) begin
    cyc = cyc + 1;
    if (tx_command_send && !cmd_d) rise_q.push_back(cyc);
    cmd_d = tx_command_send;
    if (|req_ready) begin rdy_q.push_back(req_ready); rdy_cyc_q.push_back(cyc); end
    if (timeout_err) terr_q.push_back(cyc);
    if (!m_ack) line_q.push_back(line);
  end

  typedef struct {
    logic       rst;
    logic [3:0] vld, lock;
    logic       ack;
    logic [3:0] e_rdy;
    logic       e_cmd;
    logic [7:0] e_data;
    logic [1:0] e_grant;
    logic       e_busy, e_terr;
  } vec_t;
  vec_t tbl[$];

  logic [7:0] rq_b[N_REQ][$];
  logic       rq_l[N_REQ][$];
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_vec++; n_err++;
    $display("FAIL %s: wait bound expired, actual timeout required event", name);
  endtask

  task automatic tick();
    @(posedge clk_1x_bps); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic clear_mon();
    rise_q.delete(); terr_q.delete(); rdy_cyc_q.delete(); rdy_q.delete(); line_q.delete();
    sent_q.delete();
  endtask

  task automatic wait_tx_idle(input string name);
    int n = 0;
    while (!(m_ack && !s1 && !s2 && !tx_command_send && !busy) && n < 300) begin tick(); n++; end
    if (n >= 300) fail_timeout(name);
  endtask

  function automatic logic [16:0] outs();
    return {req_ready, tx_command_send, tx_data, grant_id, busy, timeout_err};
  endfunction

  task automatic add(input logic r, input logic [3:0] v, input logic [3:0] l, input logic a,
                     input logic [3:0] er, input logic ec, input logic [7:0] ed,
                     input logic [1:0] eg, input logic eb, input logic et);
    vec_t t;
    t.rst = r; t.vld = v; t.lock = l; t.ack = a;
    t.e_rdy = er; t.e_cmd = ec; t.e_data = ed; t.e_grant = eg; t.e_busy = eb; t.e_terr = et;
    tbl.push_back(t);
  endtask

  task automatic offer(input int i);
    req_valid[i] = 1'b1;
    req_data[8*i +: 8] = rq_b[i][0];
    req_lock[i] = rq_l[i][0];
  endtask

  task automatic run_table();
    // rst vld lock ack | rdy cmd data grant busy terr
    add(1, 4'h0, 4'h0, 1, 4'h0, 0, 8'h00, 0, 0, 0);
    add(1, 4'hF, 4'h0, 1, 4'h0, 0, 8'h00, 0, 0, 0);
    add(0, 4'h0, 4'h0, 1, 4'h0, 0, 8'h00, 0, 0, 0);
    add(0, 4'h6, 4'h2, 1, 4'h0, 1, 8'h22, 1, 1, 0);  // rotation from rr_ptr=3 skips idle req0
    add(0, 4'h6, 4'h2, 1, 4'h0, 1, 8'h22, 1, 1, 0);
    add(0, 4'h6, 4'h2, 0, 4'h2, 0, 8'h22, 1, 1, 0);
    add(0, 4'h6, 4'h2, 0, 4'h0, 0, 8'h22, 1, 1, 0);
    add(0, 4'h6, 4'h2, 1, 4'h0, 0, 8'h22, 1, 0, 0);
    add(0, 4'h6, 4'h2, 1, 4'h0, 1, 8'h22, 1, 1, 0);  // lock re-grants req1 over req2
    add(0, 4'h6, 4'h0, 0, 4'h2, 0, 8'h22, 1, 1, 0);
    add(0, 4'h6, 4'h0, 1, 4'h0, 0, 8'h22, 1, 0, 0);
    add(0, 4'h6, 4'h0, 1, 4'h0, 1, 8'h33, 2, 1, 0);
    add(0, 4'h6, 4'h4, 0, 4'h4, 0, 8'h33, 2, 1, 0);
    add(0, 4'h6, 4'h4, 1, 4'h0, 0, 8'h33, 2, 0, 0);
    add(0, 4'h9, 4'h4, 0, 4'h0, 0, 8'h33, 2, 0, 0);  // locked req2 absent: lock dropped
    add(0, 4'h5, 4'h0, 1, 4'h0, 1, 8'h11, 0, 1, 0);  // rotation resumes after 2 -> req0
    for (int k = 0; k < 7; k++) add(0, 4'h5, 4'h0, 1, 4'h0, 1, 8'h11, 0, 1, 0);
    add(0, 4'h5, 4'h0, 0, 4'h1, 0, 8'h11, 0, 1, 0);  // ack on terminal count beats timeout
    add(0, 4'h0, 4'h0, 1, 4'h0, 0, 8'h11, 0, 0, 0);
    add(0, 4'h1, 4'h0, 1, 4'h0, 1, 8'h11, 0, 1, 0);
    for (int k = 0; k < 7; k++) add(0, 4'h1, 4'h0, 1, 4'h0, 1, 8'h11, 0, 1, 0);
    add(0, 4'h1, 4'h0, 1, 4'h0, 0, 8'h11, 0, 1, 1);  // timeout
    add(0, 4'h1, 4'h0, 1, 4'h0, 0, 8'h11, 0, 1, 0);
    add(0, 4'h1, 4'h0, 1, 4'h0, 0, 8'h11, 0, 1, 0);
    add(0, 4'h1, 4'h0, 1, 4'h0, 0, 8'h11, 0, 0, 0);
    add(0, 4'h1, 4'h0, 1, 4'h0, 1, 8'h11, 0, 1, 0);
    add(1, 4'h1, 4'h0, 1, 4'h0, 0, 8'h00, 0, 0, 0);  // reset from REQ
    add(0, 4'h0, 4'h0, 1, 4'h0, 0, 8'h00, 0, 0, 0);
    tx_mode = 1'b1;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; req_valid = tbl[i].vld; req_lock = tbl[i].lock; force_ack = tbl[i].ack;
      tick();
      check($sformatf("vec%0d", i), 32'(outs()),
            32'({tbl[i].e_rdy, tbl[i].e_cmd, tbl[i].e_data, tbl[i].e_grant, tbl[i].e_busy,
                 tbl[i].e_terr}));
    end
    rst = 1'b0; req_valid = '0; req_lock = '0; force_ack = 1'b1;
  endtask

  task automatic run_t1();
    int n = 0;
    logic [9:0] bits = '0;
    tx_mode = 1'b0; wait_tx_idle("t1_pre"); do_reset(); clear_mon();
    req_data = '0; req_data[7:0] = 8'hA5; req_valid = 4'b0001;
    while (!req_ready[0] && n < 100) begin tick(); n++; end
    if (n >= 100) fail_timeout("t1_ready");
    req_valid = '0;
    wait_tx_idle("t1_done");
    check("t1_latency", (rise_q.size() > 0 && rdy_cyc_q.size() > 0) ?
          32'(rdy_cyc_q[0] - rise_q[0]) : 32'hFFFF, 32'd4);
    check("t1_ready_count", rdy_q.size(), 1);
    check("t1_ready_vec", rdy_q.size() > 0 ? 32'(rdy_q[0]) : 32'hFFFF, 32'h1);
    check("t1_line_len", line_q.size(), 10);
    for (int i = 0; i < 10 && i < line_q.size(); i++) bits[9-i] = line_q[i];
    check("t1_line_bits", 32'(bits), 32'(10'b0101001011));
  endtask

  task automatic run_t2();
    int n = 0;
    logic [7:0] exp_b[5];
    logic [3:0] exp_r[5];
    exp_b = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    exp_r = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    wait_tx_idle("t2_pre"); do_reset(); clear_mon();
    req_data = {8'h13, 8'h12, 8'h11, 8'h10}; req_valid = '1;
    while (sent_q.size() < 5 && n < 400) begin tick(); n++; end
    if (n >= 400) fail_timeout("t2_frames");
    req_valid = '0;
    wait_tx_idle("t2_done");
    check("t2_sent_count", sent_q.size(), 5);
    check("t2_ready_count", rdy_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_byte%0d", i), i < sent_q.size() ? 32'(sent_q[i]) : 32'hFFFF, 32'(exp_b[i]));
      check($sformatf("t2_ready%0d", i), i < rdy_q.size() ? 32'(rdy_q[i]) : 32'hFFFF, 32'(exp_r[i]));
    end
  endtask

  task automatic run_t3();
    int n = 0, p1 = 0;
    logic [7:0] b1[3];
    logic       l1[3];
    logic [7:0] exp_b[4];
    b1 = '{8'h01, 8'h02, 8'h03}; l1 = '{1'b1, 1'b1, 1'b0};
    exp_b = '{8'h01, 8'h02, 8'h03, 8'h77};
    wait_tx_idle("t3_pre"); do_reset(); clear_mon();
    req_data = '0; req_data[15:8] = b1[0]; req_lock[1] = l1[0]; req_data[23:16] = 8'h77;
    req_valid = 4'b0110;
    while ((p1 < 3 || req_valid[2]) && n < 600) begin
      tick(); n++;
      if (req_ready[1]) begin
        p1++;
        if (p1 < 3) begin req_data[15:8] = b1[p1]; req_lock[1] = l1[p1]; end
        else begin req_valid[1] = 1'b0; req_lock[1] = 1'b0; end
      end
      if (req_ready[2]) req_valid[2] = 1'b0;
    end
    if (n >= 600) fail_timeout("t3_frames");
    wait_tx_idle("t3_done");
    check("t3_sent_count", sent_q.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t3_byte%0d", i), i < sent_q.size() ? 32'(sent_q[i]) : 32'hFFFF, 32'(exp_b[i]));
  endtask

  task automatic run_t4();
    int n = 0;
    tx_mode = 1'b1; force_ack = 1'b1; do_reset(); clear_mon();
    req_data = '0; req_data[7:0] = 8'h5A; req_valid = 4'b0001;
    while (rise_q.size() < 2 && n < 100) begin tick(); n++; end
    if (n >= 100) fail_timeout("t4_regrant");
    req_valid = '0;
    check("t4_timeout_delay", (rise_q.size() > 0 && terr_q.size() > 0) ?
          32'(terr_q[0] - rise_q[0]) : 32'hFFFF, 32'(ACK_TIMEOUT));
    check("t4_regrant_delay", (rise_q.size() > 1 && terr_q.size() > 0) ?
          32'(rise_q[1] - terr_q[0]) : 32'hFFFF, 32'd4);
    check("t4_no_ready", rdy_q.size(), 0);
    n = 0;
    while (busy && n < 60) begin tick(); n++; end
    if (n >= 60) fail_timeout("t4_drain");
    tx_mode = 1'b0;
  endtask

  task automatic run_t5();
    int n = 0, early = 0;
    tx_mode = 1'b0; wait_tx_idle("t5_pre"); do_reset(); clear_mon();
    req_data = '0; req_data[7:0] = 8'h3C; req_valid = 4'b0001;
    while (!req_ready[0] && n < 100) begin tick(); n++; end
    if (n >= 100) fail_timeout("t5_ready");
    rst = 1'b1; tick(); rst = 1'b0;
    check("t5_reset_outputs", 32'(outs()), 32'h0);
    n = 0;
    while (!m_ack && n < 100) begin
      if (tx_command_send) early++;
      tick(); n++;
    end
    if (n >= 100) fail_timeout("t5_ack");
    check("t5_no_grant_while_tx_busy", early, 0);
    check("t5_cmd_at_ack_rise", tx_command_send, 1'b0);
    tick();
    check("t5_grant_after_ack", {tx_command_send, grant_id}, {1'b1, 2'd0});
    req_valid = '0;
  endtask

  task automatic run_random();
    int total = 0, acked = 0, m_last = N_REQ - 1, m_lock = -1, m_inflight = -1, exp_w;
    logic prev_cmd = 1'b0, lockf;
    wait_tx_idle("rnd_pre"); do_reset(); clear_mon(); exp_q.delete();
    req_valid = '0; req_lock = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rq_b[i].delete(); rq_l[i].delete();
      for (int p = 0; p < int'($urandom_range(2, 4)); p++) begin
        int len = $urandom_range(1, 3);
        for (int j = 0; j < len; j++) begin
          rq_b[i].push_back(8'($urandom)); rq_l[i].push_back(j < len - 1);
          total++;
        end
      end
    end
    for (int c = 0; c < 8000 && acked < total; c++) begin
      tick();
      if (tx_command_send && !prev_cmd) begin
        exp_w = -1;
        if (m_lock >= 0 && req_valid[m_lock]) exp_w = m_lock;
        else for (int d = 1; d <= N_REQ; d++) begin
          int i = (m_last + d) % N_REQ;
          if (exp_w < 0 && req_valid[i]) exp_w = i;
        end
        check("rnd_grant", 32'(grant_id), 32'(exp_w));
        if (exp_w >= 0) begin
          check("rnd_data", 32'(tx_data), rq_b[exp_w].size() > 0 ? 32'(rq_b[exp_w][0]) : 32'hFFFF);
          m_last = exp_w;
        end
        m_inflight = exp_w;
      end
      prev_cmd = tx_command_send;
      if (|req_ready) begin
        check("rnd_ready", 32'(req_ready), m_inflight >= 0 ? (32'd1 << m_inflight) : 32'd0);
        if (m_inflight >= 0 && rq_b[m_inflight].size() > 0) begin
          exp_q.push_back(rq_b[m_inflight][0]);
          lockf = rq_l[m_inflight][0];
          void'(rq_b[m_inflight].pop_front()); void'(rq_l[m_inflight].pop_front());
          m_lock = lockf ? m_inflight : -1;
          req_valid[m_inflight] = 1'b0; req_lock[m_inflight] = 1'b0;
          if (lockf && rq_b[m_inflight].size() > 0) offer(m_inflight);
          acked++;
        end
        m_inflight = -1;
      end
      for (int i = 0; i < N_REQ; i++)
        if (!req_valid[i] && rq_b[i].size() > 0 && $urandom_range(0, 3) == 0) offer(i);
    end
    if (acked < total) fail_timeout("rnd_traffic");
    req_valid = '0;
    wait_tx_idle("rnd_done");
    check("rnd_sent_count", sent_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++)
      check($sformatf("rnd_byte%0d", i), 32'(sent_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    run_table();
    run_t1();
    run_t2();
    run_t3();
    run_t4();
    run_t5();
    run_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, actual running required finished");
    $fatal(1, "watchdog");
  end

endmodule
